// File: rtl/datapath_pkg.sv
// Shared definitions for the 3-stage R-type datapath: instruction field
// positions, funct encodings, ALU operation enumeration and the decoder.
package datapath_pkg;

  localparam int INSTR_W  = 32;
  localparam int OP_LSB   = 26;
  localparam int RS_LSB   = 21;
  localparam int RT_LSB   = 16;
  localparam int RD_LSB   = 11;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b001000;
  localparam logic [5:0] FUNCT_SUB = 6'b100011;
  localparam logic [5:0] FUNCT_AND = 6'b100101;
  localparam logic [5:0] FUNCT_OR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    legal;
    alu_op_e op;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.legal = (op == OP_RTYPE);
    d.op    = ALU_ADD;
    case (funct)
      FUNCT_ADD: d.op = ALU_ADD;
      FUNCT_SUB: d.op = ALU_SUB;
      FUNCT_AND: d.op = ALU_AND;
      FUNCT_OR:  d.op = ALU_OR;
      FUNCT_NOR: d.op = ALU_NOR;
      FUNCT_SLT: d.op = ALU_SLT;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational ALU; ADD/SUB wrap modulo 2^WIDTH, SLT compares as signed.
module alu_param
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e                 op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/datapath_segmentado.sv
// Three-stage pipeline (ID -> EX -> WB) with full operand forwarding,
// a register file with r0 hardwired to zero and a direct load port.
module datapath_segmentado
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruccion_r,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [WIDTH-1:0]   load_data,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic [AW-1:0]      res_rd,
  output logic               tr_zf,
  output logic               illegal
);

  logic signed [WIDTH-1:0] rf_q [NREG];
  logic                    accept;

  logic                    vld_p0_q;
  logic [INSTR_W-1:0]      instr_p0_q;
  logic                    vld_p1_q, ill_p1_q;
  alu_op_e                 op_p1_q;
  logic signed [WIDTH-1:0] opa_p1_q, opb_p1_q;
  logic [AW-1:0]           rd_p1_q;
  logic                    vld_p2_q, ill_p2_q;
  logic signed [WIDTH-1:0] res_p2_q;
  logic [AW-1:0]           rd_p2_q;

  logic                    res_valid_q, tr_zf_q, illegal_q;
  logic [WIDTH-1:0]        res_data_q;
  logic [AW-1:0]           res_rd_q;

  dec_t                    dec_p0;
  logic [AW-1:0]           rs_p0, rt_p0, rd_p0;
  logic signed [WIDTH-1:0] opa_p1_d, opb_p1_d, alu_res_p1;
  logic                    wr_p1, wr_p2, retire_p2;
  logic                    unused_instr_bits;

  assign instr_ready = !load_en;
  assign accept      = instr_valid && instr_ready;

  // ID stage: decode and operand selection
  assign dec_p0 = decode(instr_p0_q[OP_LSB +: 6], instr_p0_q[FUNCT_LSB +: 6]);
  assign rs_p0  = instr_p0_q[RS_LSB +: AW];
  assign rt_p0  = instr_p0_q[RT_LSB +: AW];
  assign rd_p0  = instr_p0_q[RD_LSB +: AW];
  assign unused_instr_bits = ^instr_p0_q;

  assign wr_p1     = vld_p1_q && !ill_p1_q && (rd_p1_q != '0);
  assign retire_p2 = vld_p2_q && !ill_p2_q;
  assign wr_p2     = retire_p2 && (rd_p2_q != '0);

  // Youngest producer wins: EX result, then WB result, then the register file.
  always_comb begin
    opa_p1_d = rf_q[rs_p0];
    if (rs_p0 == '0)                         opa_p1_d = '0;
    else if (wr_p1 && (rd_p1_q == rs_p0))    opa_p1_d = alu_res_p1;
    else if (wr_p2 && (rd_p2_q == rs_p0))    opa_p1_d = res_p2_q;
  end

  always_comb begin
    opb_p1_d = rf_q[rt_p0];
    if (rt_p0 == '0)                         opb_p1_d = '0;
    else if (wr_p1 && (rd_p1_q == rt_p0))    opb_p1_d = alu_res_p1;
    else if (wr_p2 && (rd_p2_q == rt_p0))    opb_p1_d = res_p2_q;
  end

  // EX stage
  alu_param #(.WIDTH(WIDTH)) u_alu (
    .op     (op_p1_q),
    .a      (opa_p1_q),
    .b      (opb_p1_q),
    .result (alu_res_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q    <= 1'b0;
      instr_p0_q  <= '0;
      vld_p1_q    <= 1'b0;
      ill_p1_q    <= 1'b0;
      op_p1_q     <= ALU_ADD;
      opa_p1_q    <= '0;
      opb_p1_q    <= '0;
      rd_p1_q     <= '0;
      vld_p2_q    <= 1'b0;
      ill_p2_q    <= 1'b0;
      res_p2_q    <= '0;
      rd_p2_q     <= '0;
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      tr_zf_q     <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
    end else begin
      vld_p0_q <= accept;
      if (accept) instr_p0_q <= instruccion_r;
      vld_p1_q <= vld_p0_q;
      ill_p1_q <= !dec_p0.legal;
      op_p1_q  <= dec_p0.op;
      opa_p1_q <= opa_p1_d;
      opb_p1_q <= opb_p1_d;
      rd_p1_q  <= rd_p0;
      vld_p2_q <= vld_p1_q;
      ill_p2_q <= ill_p1_q;
      res_p2_q <= alu_res_p1;
      rd_p2_q  <= rd_p1_q;
      // WB stage: outputs register alongside the register-file write
      res_valid_q <= retire_p2;
      illegal_q   <= vld_p2_q && ill_p2_q;
      if (retire_p2) begin
        res_data_q <= res_p2_q;
        res_rd_q   <= rd_p2_q;
        tr_zf_q    <= (res_p2_q == '0);
      end
    end
  end

  // The WB write is issued last so it overrides a load to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (load_en && (load_addr != '0)) rf_q[load_addr] <= load_data;
      if (wr_p2) rf_q[rd_p2_q] <= res_p2_q;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign tr_zf     = tr_zf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_datapath_segmentado.sv
// Scoreboard bench: a 32-bit/32-register instance and an 8-bit/8-register one.
module tb_datapath_segmentado;

  localparam logic [5:0] F_ADD = 6'h08, F_SUB = 6'h23, F_AND = 6'h25,
                         F_OR  = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;

  typedef struct {
    bit          ill;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          zf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, b_rst;
  logic        a_instr_valid, a_instr_ready, a_load_en;
  logic [31:0] a_instr, a_load_data, a_res_data;
  logic [4:0]  a_load_addr, a_res_rd;
  logic        a_res_valid, a_tr_zf, a_illegal;
  logic        b_instr_valid, b_instr_ready, b_load_en;
  logic [31:0] b_instr;
  logic [7:0]  b_load_data, b_res_data;
  logic [2:0]  b_load_addr, b_res_rd;
  logic        b_res_valid, b_tr_zf, b_illegal;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datapath_segmentado #(.WIDTH(32), .NREG(32)) dut_a (
    .clk(clk), .rst(rst), .instr_valid(a_instr_valid), .instr_ready(a_instr_ready),
    .instruccion_r(a_instr), .load_en(a_load_en), .load_addr(a_load_addr),
    .load_data(a_load_data), .res_valid(a_res_valid), .res_data(a_res_data),
    .res_rd(a_res_rd), .tr_zf(a_tr_zf), .illegal(a_illegal)
  );

  datapath_segmentado #(.WIDTH(8), .NREG(8)) dut_b (
    .clk(clk), .rst(b_rst), .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
    .instruccion_r(b_instr), .load_en(b_load_en), .load_addr(b_load_addr),
    .load_data(b_load_data), .res_valid(b_res_valid), .res_data(b_res_data),
    .res_rd(b_res_rd), .tr_zf(b_tr_zf), .illegal(b_illegal)
  );

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic observe(input bit is_b, input string tag, input bit r, input bit v,
                         input bit il, input logic [31:0] d, input logic [4:0] rd,
                         input bit zf);
    exp_t e;
    int   depth;
    if (r) begin
      check({tag, " reset res_valid"}, 32'(v), 32'd0);
      check({tag, " reset illegal"}, 32'(il), 32'd0);
      check({tag, " reset res_data"}, d, 32'd0);
      check({tag, " reset res_rd"}, 32'(rd), 32'd0);
      check({tag, " reset tr_zf"}, 32'(zf), 32'd0);
    end else if (v || il) begin
      depth = is_b ? qb.size() : qa.size();
      if (depth == 0) begin
        nchk++;
        nfail++;
        $display("FAIL %s unexpected output: res_valid=%0b illegal=%0b data=%0h, required none",
                 tag, v, il, d);
      end else begin
        if (is_b) e = qb.pop_front();
        else      e = qa.pop_front();
        check({tag, " latency"}, 32'(cyc - e.cyc), 32'd3);
        check({tag, " res_valid"}, 32'(v), 32'(!e.ill));
        check({tag, " illegal"}, 32'(il), 32'(e.ill));
        check({tag, " tr_zf"}, 32'(zf), 32'(e.zf));
        if (!e.ill) begin
          check({tag, " res_data"}, d, e.data);
          check({tag, " res_rd"}, 32'(rd), 32'(e.rd));
        end
      end
    end
  endtask

  // Monitor: compares every presented output against the queued expectation.
  always @(negedge clk) begin
    observe(1'b0, "A", rst, a_res_valid, a_illegal, a_res_data, a_res_rd, a_tr_zf);
    observe(1'b1, "B", b_rst, b_res_valid, b_illegal, 32'(b_res_data), 5'(b_res_rd), b_tr_zf);
    if (done || cyc > 3000) begin
      if (!done) begin
        nfail++;
        $display("FAIL watchdog: stimulus incomplete at cycle %0d, required done by 3000", cyc);
      end
      check("A queue drained", 32'(qa.size()), 32'd0);
      check("B queue drained", 32'(qb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input bit is_b, input logic [4:0] addr, input logic [31:0] data);
    if (is_b) begin b_load_en = 1'b1; b_load_addr = addr[2:0]; b_load_data = data[7:0]; end
    else      begin a_load_en = 1'b1; a_load_addr = addr;      a_load_data = data;      end
    @(posedge clk);
    #1;
    a_load_en = 1'b0;
    b_load_en = 1'b0;
  endtask

  task automatic send(input bit is_b, input logic [31:0] ins, input bit push, input bit ill,
                      input logic [31:0] data, input logic [4:0] rd, input bit zf);
    exp_t e;
    if (is_b) begin b_instr_valid = 1'b1; b_instr = ins; end
    else      begin a_instr_valid = 1'b1; a_instr = ins; end
    @(posedge clk);
    #1;
    a_instr_valid = 1'b0;
    b_instr_valid = 1'b0;
    e.ill = ill; e.data = data; e.rd = rd; e.zf = zf; e.cyc = cyc;
    if (push) begin
      if (is_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic exe(input bit is_b, input logic [31:0] ins, input logic [31:0] data,
                     input logic [4:0] rd, input bit zf);
    send(is_b, ins, 1'b1, 1'b0, data, rd, zf);
  endtask

  task automatic bad(input logic [31:0] ins, input bit zf);
    send(1'b0, ins, 1'b1, 1'b1, 32'd0, 5'd0, zf);
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    a_instr_valid = 1'b0; a_instr = '0; a_load_en = 1'b0; a_load_addr = '0; a_load_data = '0;
    b_instr_valid = 1'b0; b_instr = '0; b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
    idle(3);
    rst = 1'b0; b_rst = 1'b0;

    load(0, 1, 32'd5);
    load(0, 2, 32'd3);
    exe(0, rtype(0, 1, 2, 3, F_ADD), 32'd8, 3, 0);
    idle(4);
    exe(0, rtype(0, 1, 1, 4, F_SUB), 32'd0, 4, 1);
    exe(0, rtype(0, 2, 1, 5, F_SLT), 32'd1, 5, 0);
    idle(4);
    exe(0, rtype(0, 1, 2, 3, F_ADD), 32'd8, 3, 0);
    exe(0, rtype(0, 3, 0, 4, F_OR),  32'd8, 4, 0);
    exe(0, rtype(0, 3, 4, 5, F_AND), 32'd8, 5, 0);
    idle(4);
    load(0, 1, 32'h7FFF_FFFF);
    exe(0, rtype(0, 1, 1, 6, F_ADD), 32'hFFFF_FFFE, 6, 0);
    exe(0, rtype(0, 6, 0, 7, F_SLT), 32'd1, 7, 0);
    idle(4);
    bad(rtype(0, 1, 2, 8, 6'h00), 0);
    bad(rtype(6'h01, 1, 1, 8, F_ADD), 0);
    exe(0, rtype(0, 8, 0, 9, F_OR), 32'd0, 9, 1);
    bad(rtype(0, 1, 2, 8, 6'h3F), 1);
    exe(0, rtype(0, 1, 2, 0, F_ADD), 32'h8000_0002, 0, 0);
    exe(0, rtype(0, 0, 2, 9, F_ADD), 32'd3, 9, 0);
    exe(0, rtype(0, 0, 0, 10, F_NOR), 32'hFFFF_FFFF, 10, 0);
    exe(0, rtype(0, 2, 1, 12, F_SUB), 32'h8000_0004, 12, 0);
    idle(4);
    // Load and writeback hit r10 on the same edge; writeback value must survive.
    exe(0, rtype(0, 2, 2, 10, F_ADD), 32'd6, 10, 0);
    idle(2);
    load(0, 10, 32'd99);
    exe(0, rtype(0, 10, 0, 11, F_OR), 32'd6, 11, 0);
    idle(5);
    send(0, rtype(0, 1, 2, 3, F_ADD), 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
    send(0, rtype(0, 3, 3, 4, F_ADD), 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
    #2 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
    exe(0, rtype(0, 1, 2, 3, F_ADD), 32'd0, 3, 1);
    exe(0, rtype(0, 6, 5, 8, F_OR),  32'd0, 8, 1);
    idle(5);

    load(1, 1, 32'd200);
    load(1, 2, 32'd200);
    exe(1, rtype(0, 9, 10, 11, F_ADD), 32'd144, 3, 0);
    exe(1, rtype(0, 3, 0, 4, F_OR), 32'd144, 4, 0);
    idle(4);
    send(1, rtype(0, 1, 2, 3, F_ADD), 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
    send(1, rtype(0, 1, 1, 4, F_ADD), 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
    #2 b_rst = 1'b1;
    idle(2);
    b_rst = 1'b0;
    idle(5);
    exe(1, rtype(0, 1, 2, 5, F_ADD), 32'd0, 5, 1);
    idle(6);
    done = 1'b1;
  end

endmodule

// File: doc/datapath_segmentado.md
DATAPATH_SEGMENTADO -- requirements
Module: datapath_segmentado

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/register width (8..64).
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, 2..32); AW = clog2(NREG).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port instr_valid  in  1  instruccion_r holds an instruction.
REQ-006 SHALL have port instr_ready  out  1  instruction accepted when instr_valid && instr_ready.
REQ-007 SHALL have port instruccion_r  in  32  R-type: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct.
REQ-008 SHALL have port load_en  in  1, load_addr  in  AW, load_data  in  WIDTH  direct register-file write.
REQ-009 SHALL have port res_valid  out  1, res_data  out  WIDTH, res_rd  out  AW  writeback result.
REQ-010 SHALL have port tr_zf  out  1  zero flag of last executed legal instruction.
REQ-011 SHALL have port illegal  out  1  one-cycle pulse for a rejected instruction at writeback.

Function
REQ-012 SHALL be a 3-stage pipeline: ID (decode, register read), EX (ALU), WB (register write, outputs); one instruction per cycle max.
REQ-013 SHALL assert res_valid exactly 3 cycles after acceptance edge (accept at edge N -> res_valid high after edge N+3, one cycle), with res_data/res_rd of that instruction.
REQ-014 SHALL decode funct with op==0: 001000 ADD, 100011 SUB, 100101 AND, 100110 OR, 100111 NOR, 101010 SLT.
REQ-015 SHALL treat op!=0 or any other funct as illegal: no register write, res_valid low, illegal pulses in WB cycle, tr_zf unchanged.
REQ-016 SHALL compute ADD/SUB modulo 2^WIDTH (carry/overflow discarded); SLT is signed two's-complement, result 1 or 0 zero-extended.
REQ-017 SHALL use the low AW bits of rs/rt/rd fields; upper bits ignored.
REQ-018 SHALL hardwire register 0 to zero: reads return 0, writes (instruction or load) discarded; res_valid still asserted for rd=0.
REQ-019 SHALL update tr_zf in each legal WB cycle to (result==0) and hold it otherwise.
REQ-020 SHALL forward operands: EX result over WB result over register file, for matching nonzero source index; back-to-back dependent instructions need no stall.
REQ-021 SHALL drive instr_ready = !load_en; load has priority, writes load_data at the edge where load_en is high.
REQ-022 SHALL, if load and WB target the same register in one cycle, keep the WB value (WB wins).
REQ-023 SHALL treat bubbles (no acceptance) as invalid stage entries that neither write nor affect outputs.

Reset
REQ-024 SHALL on rst clear all registers to 0, all stage valid bits to 0, res_valid=0, res_data=0, res_rd=0, tr_zf=0, illegal=0, immediately and independent of clk.
REQ-025 SHALL discard in-flight instructions on reset mid-operation; none complete after release.
REQ-026 SHALL hold instr_ready per REQ-021 during reset; instructions presented during reset are not accepted.

Structure
REQ-027 SHALL place funct constants, the ALU-operation enumeration and field-position constants in a shared package datapath_pkg.
REQ-028 SHALL implement the ALU as sub-module alu_param (WIDTH parameter, combinational, op in, a/b in, result out).
REQ-029 SHALL keep the register file inside datapath_segmentado.

Verification
REQ-030 SHALL: load r1=5, r2=3; ADD rd=3,rs=1,rt=2 -> 3 cycles later res_valid, res_data=8, res_rd=3, tr_zf=0.
REQ-031 SHALL: SUB r4=r1-r1 then SLT r5=r2<r1 back-to-back -> res_data 0 (tr_zf=1) then 1 (tr_zf=0), consecutive cycles.
REQ-032 SHALL: r1=0x7FFFFFFF, ADD r6=r1+r1 (WIDTH=32) -> 0xFFFFFFFE; SLT r7=r6<r0 -> 1 (signed).
REQ-033 SHALL: ADD r3=r1+r2, then OR r4=r3|r0, then AND r5=r3&r4 consecutively (r1=5,r2=3) -> 8, 8, 8 via forwarding.
REQ-034 SHALL: funct 000000 -> illegal pulse at cycle 3, no write, tr_zf held; ADD rd=0 -> res_valid, r0 still reads 0.
REQ-035 SHALL: assert rst with 2 instructions in flight -> no res_valid afterward, all registers 0; repeat at WIDTH=8, NREG=8 with 200+200 -> 144.
